// File: rtl/rah_wr_arbiter_pkg.sv
// rah_wr_arbiter_pkg
// Shared types and helpers for the RAH encoder write-port arbiter.
//   arb_state_e      : arbiter FSM state encoding (IDLE / ARB / GRANT)
//   RAH_PACKET_WIDTH : width of one RAH packet, default data width of the arbiter
//   rrNext()         : round-robin successor of an index, wrapping at n-1 -> 0
package rah_wr_arbiter_pkg;

  localparam int RAH_PACKET_WIDTH = 48;

  typedef enum logic [1:0] {
    RAH_ARB_IDLE  = 2'd0,
    RAH_ARB_ARB   = 2'd1,
    RAH_ARB_GRANT = 2'd2
  } arb_state_e;

  // Explicit compare instead of modulo so non-power-of-two NUM_REQ wraps correctly.
  function automatic int unsigned rrNext(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rah_wr_arbiter_rr_priority_picker.sv
// rr_priority_picker
// Combinational round-robin picker: finds the first asserted request when
// scanning rr_ptr_i, rr_ptr_i+1, ... (mod NUM_REQ).
//   req_i     in  NUM_REQ  request vector
//   rr_ptr_i  in  IDX_W    index with highest priority this round
//   found_o   out 1        at least one request is asserted
//   index_o   out IDX_W    chosen index (0 when found_o is low)
module rr_priority_picker
  import rah_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   index_o
);

  // Scan from the farthest offset down to offset 0 so the closest hit to
  // rr_ptr_i is the last one written and therefore wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx     = '0;
    found_o = 1'b0;
    index_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        found_o = 1'b1;
        index_o = idx;
      end
    end
  end

endmodule

// File: rtl/rah_wr_arbiter.sv
// rah_wr_arbiter
// Round-robin burst arbiter letting NUM_REQ RAH app engines share one RAH
// encoder write lane. One requester is granted at a time for up to MAX_BURST
// beats, then the grant rotates.
//   clk                 in   1                 clock
//   rst                 in   1                 asynchronous active-high reset
//   req_valid_i         in   NUM_REQ           requester i has a packet
//   req_data_i          in   NUM_REQ*DW        packet i in bits [i*DW +: DW]
//   req_ready_o         out  NUM_REQ           beat from i accepted when valid&ready
//   fifo_almost_full_i  in   1                 encoder FIFO has <=1 free slot
//   wr_en_o             out  1                 registered write strobe to encoder FIFO
//   wr_data_o           out  DW                registered packet to encoder FIFO
//   grant_id_o          out  $clog2(NUM_REQ)   current / last grantee
//   busy_o              out  1                 high while in GRANT
module rah_wr_arbiter
  import rah_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = RAH_PACKET_WIDTH,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_almost_full_i,
  output logic                          wr_en_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_index;
  logic                  grantee_valid;
  logic                  accept;
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_arr[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .index_o  (pick_index)
  );

  // Almost-full rather than full gates ready: the write for a beat accepted
  // this cycle lands one cycle later and still needs a free slot.
  assign grantee_valid = req_valid_i[grant_id_q];
  assign accept        = (state_q == RAH_ARB_GRANT) && grantee_valid && !fifo_almost_full_i;

  always_comb begin
    req_ready_o = '0;
    if (state_q == RAH_ARB_GRANT) begin
      req_ready_o[grant_id_q] = !fifo_almost_full_i;
    end
  end

  // Next-state logic. Exit from GRANT is judged after counting this cycle's
  // beat, so a valid drop on the final beat yields a single exit. Going to ARB
  // on any valid (grantee included) re-grants a sole requester after a full
  // burst with exactly one bubble; after a valid drop the grantee is already
  // excluded because its valid is low.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    unique case (state_q)
      RAH_ARB_IDLE: begin
        if (|req_valid_i) begin
          state_d = RAH_ARB_ARB;
        end
      end
      RAH_ARB_ARB: begin
        if (pick_found) begin
          grant_id_d = pick_index;
          beat_cnt_d = '0;
          state_d    = RAH_ARB_GRANT;
        end else begin
          state_d = RAH_ARB_IDLE;
        end
      end
      RAH_ARB_GRANT: begin
        if (accept) begin
          wr_en_d    = 1'b1;
          wr_data_d  = req_data_arr[grant_id_q];
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if ((accept && (beat_cnt_q == CNT_W'(MAX_BURST - 1))) || !grantee_valid) begin
          rr_ptr_d = IDX_W'(rrNext(32'(grant_id_q), NUM_REQ));
          state_d  = (|req_valid_i) ? RAH_ARB_ARB : RAH_ARB_IDLE;
        end
      end
      default: state_d = RAH_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RAH_ARB_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_data_o  = wr_data_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q == RAH_ARB_GRANT);

endmodule

// File: tb/tb_rah_wr_arbiter.sv
// tb_rah_wr_arbiter
// Self-checking bench for rah_wr_arbiter. Requesters are per-index packet
// queues that hold valid while non-empty. A transaction-level model walks the
// queues with round-robin burst rules to predict the ordered stream of
// (grantee, packet, gap-before-beat) that the encoder write port should see.
module tb_rah_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 48;
  localparam int MAX_BURST = 16;
  localparam int IW        = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ*DW-1:0]    reqData;
  logic [NUM_REQ-1:0]       reqReady;
  logic                     fifoAlmostFull;
  logic                     wrEn;
  logic [DW-1:0]            wrData;
  logic [IW-1:0]            grantId;
  logic                     busy;

  typedef struct {
    int          id;
    logic [DW-1:0] data;
    int          gap;
  } beat_t;

  logic [DW-1:0] drvQ [NUM_REQ][$];
  beat_t         expQ[$];
  int            nCompared = 0;
  int            nMismatch = 0;
  int            cycle     = 0;
  int            lastWr    = -100;
  int            rrModel   = 0;
  bit            checkGaps = 1'b0;
  logic          prevAf    = 1'b0;

  always #5 clk = ~clk;

  rah_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (reqValid),
    .req_data_i         (reqData),
    .req_ready_o        (reqReady),
    .fifo_almost_full_i (fifoAlmostFull),
    .wr_en_o            (wrEn),
    .wr_data_o          (wrData),
    .grant_id_o         (grantId),
    .busy_o             (busy)
  );

  // One comparison: counts it, and on a miss counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Requesters present the head of their queue, valid while anything is queued.
  task automatic driveInputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      reqValid[i] = (drvQ[i].size() > 0);
      reqData[i*DW +: DW] = (drvQ[i].size() > 0) ? drvQ[i][0] : '0;
    end
  endtask

  task automatic loadReq(input int id, input int n);
    logic [63:0] tmp;
    for (int k = 0; k < n; k++) begin
      tmp = {$urandom, $urandom};
      drvQ[id].push_back(tmp[DW-1:0]);
    end
  endtask

  task automatic clearAll();
    for (int i = 0; i < NUM_REQ; i++) drvQ[i].delete();
    expQ.delete();
  endtask

  // Predicted write stream: serve non-empty queues round-robin from rrModel,
  // min(remaining, MAX_BURST) beats per grant. With no back-pressure a burst
  // ending on its beat cap is followed by one idle cycle; one ending because
  // the requester ran dry is followed by two (drop seen, then arbitration).
  task automatic buildModel();
    int pos [NUM_REQ];
    int rem [NUM_REQ];
    int g, len, prevLen;
    bit first;
    first   = 1'b1;
    prevLen = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0;
      rem[i] = drvQ[i].size();
    end
    while (1) begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (rrModel + k) % NUM_REQ;
        if (g < 0 && rem[idx] > 0) g = idx;
      end
      if (g < 0) break;
      len = (rem[g] < MAX_BURST) ? rem[g] : MAX_BURST;
      for (int k = 0; k < len; k++) begin
        beat_t b;
        b.id   = g;
        b.data = drvQ[g][pos[g] + k];
        b.gap  = (k != 0) ? 0 : (first ? -1 : ((prevLen == MAX_BURST) ? 1 : 2));
        expQ.push_back(b);
      end
      pos[g] += len;
      rem[g] -= len;
      prevLen = len;
      first   = 1'b0;
      rrModel = (g + 1) % NUM_REQ;
    end
  endtask

  // One clock: drive, sample at the falling edge, then retire accepted beats
  // just after the rising edge.
  task automatic applyStimulus(input logic af, input bit chkBusy);
    logic [NUM_REQ-1:0] acc;
    fifoAlmostFull = af;
    driveInputs();
    @(negedge clk);
    cycle++;
    if (wrEn) begin
      checkOutput("wr_en_expected", wrEn, expQ.size() > 0);
      checkOutput("wr_after_almost_full", prevAf, 1'b0);
      if (expQ.size() > 0) begin
        beat_t b;
        b = expQ.pop_front();
        checkOutput("wr_data", wrData, b.data);
        checkOutput("grant_id", grantId, b.id);
        if (checkGaps && b.gap >= 0) checkOutput("bubble_gap", cycle - lastWr - 1, b.gap);
        lastWr = cycle;
      end
    end
    checkOutput("ready_at_most_one", $countones(reqReady) <= 1, 1'b1);
    if (af) checkOutput("ready_stalled", reqReady, '0);
    if (reqReady != '0) checkOutput("busy_with_ready", busy, 1'b1);
    if (chkBusy) checkOutput("busy_during_stall", busy, 1'b1);
    acc = reqValid & reqReady;
    prevAf = af;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) void'(drvQ[i].pop_front());
    end
  endtask

  // mode 0: no back-pressure, gaps checked; 1: random almost_full;
  // 2: almost_full for five cycles in the middle of the first burst.
  task automatic runScenario(input string name, input int mode);
    int  steps;
    logic af;
    steps = 0;
    buildModel();
    lastWr    = -100;
    checkGaps = (mode == 0);
    $display("[TB] scenario %s: %0d beats predicted", name, expQ.size());
    while (expQ.size() > 0 && steps < 3000) begin
      if (mode == 1)      af = ($urandom_range(0, 9) < 3);
      else if (mode == 2) af = (steps >= 5 && steps < 10);
      else                af = 1'b0;
      applyStimulus(af, (mode == 2) && af);
      steps++;
    end
    checkOutput({name, "_drained"}, expQ.size(), 0);
    clearAll();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
    checkOutput({name, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, wrEn, 1'b0);
    checkOutput({tag, "_wr_data"}, wrData, '0);
    checkOutput({tag, "_grant_id"}, grantId, '0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_ready"}, reqReady, '0);
  endtask

  // Directed scenarios in sequence, then randomized rounds.
  initial begin
    int steps;
    rst            = 1'b1;
    fifoAlmostFull = 1'b0;
    reqValid       = '0;
    reqData        = '0;
    #12;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) loadReq(i, 4);
    runScenario("all_four_x4", 0);

    loadReq(0, 16);
    loadReq(1, 5);
    runScenario("drop_on_last_beat", 0);

    loadReq(0, 40);
    runScenario("single_req0_40", 0);

    loadReq(1, 48);
    loadReq(3, 48);
    runScenario("req1_req3", 0);

    loadReq(2, 16);
    runScenario("stall_grantee2", 2);

    // Asynchronous reset in the middle of a burst.
    loadReq(0, 30);
    buildModel();
    checkGaps = 1'b0;
    steps = 0;
    while ((30 - expQ.size()) < 7 && steps < 200) begin
      applyStimulus(1'b0, 1'b0);
      steps++;
    end
    checkOutput("reached_beat7", (30 - expQ.size()) >= 7, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    clearAll();
    rrModel = 0;
    prevAf  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    loadReq(0, 3);
    loadReq(1, 3);
    runScenario("post_reset", 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_REQ; i++) loadReq(i, $urandom_range(0, 40));
      runScenario((r % 2 == 0) ? "random_backpressure" : "random_free", (r % 2 == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not finish, %0d mismatched so far", nMismatch);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
